rect_loader: RTL

//  Frame-time loader feeding the per-rectangle comparators on pixel_clk.
//  On load_start, walks the rectangle table in video RAM (x, y, w, h, color per rect).

---
 rtl/rect_loader_pkg.sv | 31 +++
 rtl/rect_loader_if.sv | 11 +
 rtl/rect_loader_bank.sv | 36 +++
 rtl/rect_loader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rect_loader_pkg.sv
// rtl/rect_loader_pkg.sv - shared types and constants for the rectangle table loader
package rect_loader_pkg;

    localparam int WORDS_PER_RECT = 5;
    localparam int RECT_COORD_W   = 16;
    localparam int RECT_COLOR_W   = 16;

    // Word index within a table entry; also selects the bank field it lands in.
    typedef enum logic [2:0] {
        W_X     = 3'd0,
        W_Y     = 3'd1,
        W_W     = 3'd2,
        W_H     = 3'd3,
        W_COLOR = 3'd4
    } word_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [RECT_COORD_W-1:0] left;
        logic [RECT_COORD_W-1:0] top;
        logic [RECT_COORD_W-1:0] right;
        logic [RECT_COORD_W-1:0] bottom;
        logic [RECT_COLOR_W-1:0] color;
    } rect_t;

endpackage

// File: rtl/rect_loader_if.sv
// rtl/rect_loader_if.sv - video RAM read bus between the loader and the table RAM
interface rect_loader_if #(
    parameter int COORD_WIDTH = 16,
    parameter int ADDR_WIDTH  = 13
);
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [COORD_WIDTH-1:0] mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/rect_loader_bank.sv
// rtl/rect_loader_bank.sv - per-rectangle bound register bank with field write and bulk load
module rect_loader_bank
    import rect_loader_pkg::*;
#(
    parameter int NUM_RECTS = 64,
    parameter int IDX_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  word_t                   wr_field,
    input  logic [RECT_COORD_W-1:0] wr_data,
    input  logic                    load_en,
    input  rect_t [NUM_RECTS-1:0]   load_rects,
    output rect_t [NUM_RECTS-1:0]   rects
);

    always_ff @(posedge clk) begin
        if (reset) begin
            rects <= '0;
        end else if (load_en) begin
            rects <= load_rects;
        end else if (wr_en) begin
            case (wr_field)
                W_X:     rects[wr_idx].left   <= wr_data;
                W_Y:     rects[wr_idx].top    <= wr_data;
                W_W:     rects[wr_idx].right  <= wr_data;
                W_H:     rects[wr_idx].bottom <= wr_data;
                W_COLOR: rects[wr_idx].color  <= wr_data[RECT_COLOR_W-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rect_loader.sv
// rtl/rect_loader.sv - walks the RAM rectangle table into a bound register bank (option: RECT_LOADER_DOUBLE_BUF_EN)
module rect_loader
    import rect_loader_pkg::*;
#(
    parameter int                    COORD_WIDTH = 16,
    parameter int                    ADDR_WIDTH  = 13,
    parameter int                    NUM_RECTS   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    COLOR_WIDTH = 16
) (
    input  logic                             pixel_clk,
    input  logic                             reset,
    input  logic                             load_start,
    rect_loader_if.master                    mem,
    output logic                             busy,
    output logic                             load_done,
`ifdef RECT_LOADER_DOUBLE_BUF_EN
    input  logic                             commit,
`endif
    output logic [NUM_RECTS*COORD_WIDTH-1:0] rect_left_flat,
    output logic [NUM_RECTS*COORD_WIDTH-1:0] rect_top_flat,
    output logic [NUM_RECTS*COORD_WIDTH-1:0] rect_right_flat,
    output logic [NUM_RECTS*COORD_WIDTH-1:0] rect_bottom_flat,
    output logic [NUM_RECTS*COLOR_WIDTH-1:0] rect_color_flat
);

    localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [IDX_W-1:0]        rect_idx, cap_rect;
    word_t                   word_idx, cap_word;
    logic                    cap_valid;
    logic [COORD_WIDTH-1:0]  left_q, top_q;
    logic [COORD_WIDTH:0]    right_raw, bottom_raw;
    logic [COORD_WIDTH-1:0]  right_sum, bottom_sum;
    logic                    last_addr;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    word_t                   wr_field;
    logic [COORD_WIDTH-1:0]  wr_data;
    rect_t [NUM_RECTS-1:0]   active_rects;

    assign mem.mem_addr = addr_q;
    assign last_addr    = (rect_idx == IDX_W'(NUM_RECTS - 1)) && (word_idx == W_COLOR);

    // Carry out of the extended sum means the bound fell off the coordinate space.
    assign right_raw  = {1'b0, left_q} + {1'b0, mem.mem_data};
    assign bottom_raw = {1'b0, top_q}  + {1'b0, mem.mem_data};
    assign right_sum  = right_raw[COORD_WIDTH]  ? '1 : right_raw[COORD_WIDTH-1:0];
    assign bottom_sum = bottom_raw[COORD_WIDTH] ? '1 : bottom_raw[COORD_WIDTH-1:0];

    always_ff @(posedge pixel_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (load_start) state_next = S_FETCH;
            S_FETCH: if (last_addr)  state_next = S_DRAIN;
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        load_done = (state == S_DRAIN);
        wr_en     = cap_valid && (state != S_IDLE);
        wr_idx    = cap_rect;
        wr_field  = cap_word;
        wr_data   = mem.mem_data;
        case (cap_word)
            W_W:     wr_data = right_sum;
            W_H:     wr_data = bottom_sum;
            W_COLOR: wr_data = COORD_WIDTH'(mem.mem_data[COLOR_WIDTH-1:0]);
            default: ;
        endcase
    end

    // cap_* tag the word arriving this cycle, i.e. the address issued last cycle.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            addr_q    <= BASE_ADDR;
            rect_idx  <= '0;
            word_idx  <= W_X;
            cap_valid <= 1'b0;
            cap_rect  <= '0;
            cap_word  <= W_X;
            left_q    <= '0;
            top_q     <= '0;
        end else begin
            if (wr_en && cap_word == W_X) left_q <= mem.mem_data;
            if (wr_en && cap_word == W_Y) top_q  <= mem.mem_data;
            case (state)
                S_IDLE: begin
                    cap_valid <= 1'b0;
                    if (load_start) begin
                        addr_q   <= BASE_ADDR;
                        rect_idx <= '0;
                        word_idx <= W_X;
                    end
                end
                S_FETCH: begin
                    cap_valid <= 1'b1;
                    cap_rect  <= rect_idx;
                    cap_word  <= word_idx;
                    if (!last_addr) begin
                        addr_q <= addr_q + 1'b1;
                        if (word_idx == W_COLOR) begin
                            word_idx <= W_X;
                            rect_idx <= rect_idx + 1'b1;
                        end else begin
                            word_idx <= word_t'(word_idx + 3'd1);
                        end
                    end
                end
                default: cap_valid <= 1'b0;
            endcase
        end
    end

`ifdef RECT_LOADER_DOUBLE_BUF_EN
    rect_t [NUM_RECTS-1:0] shadow_rects;

    rect_loader_bank #(.NUM_RECTS(NUM_RECTS), .IDX_W(IDX_W)) u_shadow (
        .clk(pixel_clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_field(wr_field), .wr_data(wr_data),
        .load_en(1'b0), .load_rects('0), .rects(shadow_rects)
    );

    rect_loader_bank #(.NUM_RECTS(NUM_RECTS), .IDX_W(IDX_W)) u_active (
        .clk(pixel_clk), .reset(reset),
        .wr_en(1'b0), .wr_idx('0), .wr_field(W_X), .wr_data('0),
        .load_en(commit), .load_rects(shadow_rects), .rects(active_rects)
    );
`else
    rect_loader_bank #(.NUM_RECTS(NUM_RECTS), .IDX_W(IDX_W)) u_bank (
        .clk(pixel_clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_field(wr_field), .wr_data(wr_data),
        .load_en(1'b0), .load_rects('0), .rects(active_rects)
    );
`endif

    for (genvar i = 0; i < NUM_RECTS; i++) begin : g_flat
        assign rect_left_flat[i*COORD_WIDTH +: COORD_WIDTH]   = active_rects[i].left;
        assign rect_top_flat[i*COORD_WIDTH +: COORD_WIDTH]    = active_rects[i].top;
        assign rect_right_flat[i*COORD_WIDTH +: COORD_WIDTH]  = active_rects[i].right;
        assign rect_bottom_flat[i*COORD_WIDTH +: COORD_WIDTH] = active_rects[i].bottom;
        assign rect_color_flat[i*COLOR_WIDTH +: COLOR_WIDTH]  = active_rects[i].color;
    end

endmodule
